// File: rtl/button_manager_if.sv
// AHB-lite bus bundle for the button manager slave.
// The master modport drives the address/control phase and consumes read data;
// the slave modport is the view taken by the button manager itself.
interface button_manager_if;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;
    logic        HSEL;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HRDATA;
    logic        HREADYOUT;

    modport master (
        output HADDR,
        output HWDATA,
        output HWRITE,
        output HREADY,
        output HSEL,
        output HSIZE,
        output HTRANS,
        input  HRDATA,
        input  HREADYOUT
    );

    modport slave (
        input  HADDR,
        input  HWDATA,
        input  HWRITE,
        input  HREADY,
        input  HSEL,
        input  HSIZE,
        input  HTRANS,
        output HRDATA,
        output HREADYOUT
    );
endinterface

// File: rtl/button_manager.sv
// Button manager: AHB-lite read-side slave that synchronises and debounces
// the active-low Mode and Trip pushbuttons, flags press / long-press events,
// counts presses and raises ButtonIRQ while any event is pending.
//
// Register map (HADDR[3:2]):
//   0x0 EVENT  read-clear  [0] mode_press [1] trip_press [2] trip_long
//   0x4 LEVEL  read-only   [0] mode_held  [1] trip_held  (1 = pressed)
//   0x8 COUNT  [7:0] mode presses, [15:8] trip presses; any write clears both
//   0xC        reads 0
module button_manager #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 1024
) (
    input  logic            HCLK,
    input  logic            HRESET,
    button_manager_if.slave ahb,
    input  logic            nMode,
    input  logic            nTrip,
    output logic            ButtonIRQ
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

    localparam logic [1:0] ADDR_EVENT = 2'd0;
    localparam logic [1:0] ADDR_LEVEL = 2'd1;
    localparam logic [1:0] ADDR_COUNT = 2'd2;

    // Button index 0 = Mode, 1 = Trip. Levels are kept in raw polarity
    // (1 = released) so reset and synchroniser share the same idle value.
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            level_q, level_d;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [1:0]            press;

    logic [LONG_W-1:0]     long_cnt_q, long_cnt_d;
    logic                  long_hit;

    logic [2:0]            event_q, event_d;
    logic [7:0]            mode_cnt_q, mode_cnt_d;
    logic [7:0]            trip_cnt_q, trip_cnt_d;
    logic                  irq_q, irq_d;

    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [1:0]            addr_q, addr_d;
    logic                  addr_valid;
    logic                  ev_read;
    logic                  cnt_clr;

    // Bus bits this slave never decodes.
    logic                  unused_bus;
    assign unused_bus = ^{ahb.HWDATA, ahb.HSIZE, ahb.HADDR[31:4], ahb.HADDR[1:0]};

    assign ahb.HREADYOUT = 1'b1;
    assign ButtonIRQ     = irq_q;

    // Synchroniser chain, debounce counters and press-edge detection.
    always_comb begin
        sync1_d  = {nTrip, nMode};
        sync2_d  = sync1_q;
        level_d  = level_q;
        db_cnt_d = '0;
        press    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_MAX) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
            press[i] = level_q[i] & ~level_d[i];
        end
    end

    // Trip hold timer: counts while held, fires once on reaching the limit,
    // then parks at the limit until the button is released.
    always_comb begin
        long_cnt_d = long_cnt_q;
        long_hit   = 1'b0;
        if (level_q[1]) begin
            long_cnt_d = '0;
        end else if (long_cnt_q != LONG_MAX) begin
            long_cnt_d = long_cnt_q + 1'b1;
            long_hit   = (long_cnt_d == LONG_MAX);
        end
    end

    // AHB address-phase capture; anything other than a valid transfer drops
    // the latched read/write flags so the next data phase is idle.
    always_comb begin
        addr_valid = ahb.HSEL & ahb.HREADY & (ahb.HTRANS != 2'b00);
        rd_d       = addr_valid & ~ahb.HWRITE;
        wr_d       = addr_valid &  ahb.HWRITE;
        addr_d     = addr_valid ? ahb.HADDR[3:2] : addr_q;
    end

    // Event flags, press counters and interrupt; new events win over a
    // same-edge read-clear or counter clear.
    always_comb begin
        ev_read    = rd_q & (addr_q == ADDR_EVENT);
        cnt_clr    = wr_q & (addr_q == ADDR_COUNT);
        event_d    = (ev_read ? 3'b000 : event_q) | {long_hit, press[1], press[0]};
        mode_cnt_d = (cnt_clr ? 8'd0 : mode_cnt_q) + {7'd0, press[0]};
        trip_cnt_d = (cnt_clr ? 8'd0 : trip_cnt_q) + {7'd0, press[1]};
        irq_d      = |event_q;
    end

    // Data-phase read mux, driven straight from the latched address.
    always_comb begin
        ahb.HRDATA = 32'd0;
        if (rd_q) begin
            case (addr_q)
                ADDR_EVENT: ahb.HRDATA = {29'd0, event_q};
                ADDR_LEVEL: ahb.HRDATA = {30'd0, ~level_q};
                ADDR_COUNT: ahb.HRDATA = {16'd0, trip_cnt_q, mode_cnt_q};
                default:    ahb.HRDATA = 32'd0;
            endcase
        end
    end

    // State registers; reset returns buttons to released and aborts any transfer.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            level_q    <= 2'b11;
            db_cnt_q   <= '0;
            long_cnt_q <= '0;
            event_q    <= 3'b000;
            mode_cnt_q <= 8'd0;
            trip_cnt_q <= 8'd0;
            irq_q      <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 2'd0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            long_cnt_q <= long_cnt_d;
            event_q    <= event_d;
            mode_cnt_q <= mode_cnt_d;
            trip_cnt_q <= trip_cnt_d;
            irq_q      <= irq_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
        end
    end
endmodule

// File: tb/tb_button_manager.sv
// Directed bench for button_manager with DEBOUNCE_CYCLES=4, LONG_CYCLES=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_button_manager;
    logic HCLK;
    logic HRESET;
    logic nMode;
    logic nTrip;
    logic ButtonIRQ;

    int n_cmp;
    int n_bad;

    button_manager_if bus ();

    button_manager #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (8)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .ahb      (bus),
        .nMode    (nMode),
        .nTrip    (nTrip),
        .ButtonIRQ(ButtonIRQ)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic addr_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
    endtask

    task automatic addr_rd(input logic [31:0] a);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b0;
        bus.HADDR  = a;
    endtask

    task automatic addr_wr(input logic [31:0] a);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1;
        bus.HADDR  = a;
    endtask

    // Single read: address phase, then check data phase, then end it.
    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr_rd(a);
        tick();
        addr_idle();
        chk(tag, bus.HRDATA, exp);
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_wr(a);
        tick();
        addr_idle();
        bus.HWDATA = d;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        HRESET     = 1'b1;
        nMode      = 1'b1;
        nTrip      = 1'b1;
        bus.HADDR  = 32'd0;
        bus.HWDATA = 32'd0;
        bus.HSIZE  = 3'b010;
        bus.HREADY = 1'b1;
        addr_idle();
        ticks(3);
        HRESET = 1'b0;

        // Reset state
        chk("irq_reset", {31'd0, ButtonIRQ}, 32'd0);
        chk("hrdata_idle", bus.HRDATA, 32'd0);
        chk("hreadyout_reset", {31'd0, bus.HREADYOUT}, 32'd1);
        rd(32'h0, 32'h0, "event_reset");
        rd(32'h4, 32'h0, "level_reset");
        rd(32'h8, 32'h0, "count_reset");

        // 3-cycle glitch on Mode must be filtered
        nMode = 1'b0;
        ticks(3);
        nMode = 1'b1;
        ticks(10);
        rd(32'h4, 32'h0, "level_after_glitch");
        rd(32'h0, 32'h0, "event_after_glitch");
        chk("irq_after_glitch", {31'd0, ButtonIRQ}, 32'd0);

        // Mode press: back-to-back LEVEL reads pin the exact flip edge
        addr_rd(32'h4);
        tick();
        nMode = 1'b0;
        ticks(5);
        tick();
        chk("level_edge6", bus.HRDATA, 32'h0);
        tick();
        chk("level_edge7", bus.HRDATA, 32'h1);
        chk("irq_edge7", {31'd0, ButtonIRQ}, 32'd0);
        tick();
        chk("irq_edge8", {31'd0, ButtonIRQ}, 32'd1);
        addr_idle();
        ticks(12);
        nMode = 1'b1;
        ticks(10);
        rd(32'h8, 32'h0000_0001, "count_one_mode");
        rd(32'h4, 32'h0, "level_released");
        chk("irq_pending", {31'd0, ButtonIRQ}, 32'd1);
        rd(32'h0, 32'h1, "event_first_read");
        rd(32'h0, 32'h0, "event_second_read");
        chk("irq_cleared", {31'd0, ButtonIRQ}, 32'd0);
        chk("hreadyout_mid", {31'd0, bus.HREADYOUT}, 32'd1);

        // Second Mode press, then a Trip press landing on the EVENT clear edge
        nMode = 1'b0;
        ticks(12);
        nMode = 1'b1;
        ticks(12);
        nTrip = 1'b0;
        ticks(5);
        addr_rd(32'h0);
        tick();
        addr_idle();
        chk("event_before_collision", bus.HRDATA, 32'h1);
        tick();
        rd(32'h0, 32'h2, "event_collision");
        ticks(7);
        rd(32'h0, 32'h4, "event_long");
        ticks(20);
        rd(32'h0, 32'h0, "no_second_long");
        chk("irq_no_second_long", {31'd0, ButtonIRQ}, 32'd0);
        nTrip = 1'b1;
        ticks(12);
        rd(32'h4, 32'h0, "level_trip_released");
        rd(32'h8, 32'h0000_0102, "count_two_one");

        // Exact long-press edge: pipelined EVENT reads straddling it
        nTrip = 1'b0;
        ticks(13);
        addr_rd(32'h0);
        tick();
        chk("event_long_not_yet", bus.HRDATA, 32'h2);
        tick();
        addr_idle();
        chk("event_long_exact", bus.HRDATA, 32'h4);
        tick();
        nTrip = 1'b1;
        ticks(12);

        // Release and re-press: press and long both pending
        nTrip = 1'b0;
        ticks(20);
        rd(32'h4, 32'h2, "level_trip_held");
        rd(32'h0, 32'h6, "event_press_and_long");
        nTrip = 1'b1;
        ticks(12);
        rd(32'h8, 32'h0000_0302, "count_before_clear");

        // Counter clear by write, then 8-bit wrap of the Mode counter
        wr(32'h8, 32'hDEAD_BEEF);
        rd(32'h8, 32'h0, "count_cleared");
        for (int k = 0; k < 255; k++) begin
            nMode = 1'b0;
            ticks(8);
            nMode = 1'b1;
            ticks(8);
        end
        rd(32'h8, 32'h0000_00FF, "count_255");
        nMode = 1'b0;
        ticks(8);
        nMode = 1'b1;
        ticks(8);
        rd(32'h8, 32'h0000_0000, "count_wrap");
        rd(32'h0, 32'h1, "event_after_wrap");

        // Count clear on the same edge as a Trip press
        nTrip = 1'b0;
        ticks(5);
        addr_wr(32'h8);
        tick();
        addr_idle();
        bus.HWDATA = 32'h0000_ABCD;
        tick();
        rd(32'h8, 32'h0000_0100, "count_clear_and_press");

        // Reset in the data phase of an EVENT read with Trip held
        ticks(20);
        addr_rd(32'h0);
        tick();
        addr_idle();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        chk("hrdata_after_reset", bus.HRDATA, 32'h0);
        chk("irq_after_reset", {31'd0, ButtonIRQ}, 32'd0);
        rd(32'h0, 32'h0, "event_after_reset");
        rd(32'h4, 32'h0, "level_after_reset");
        rd(32'h8, 32'h0, "count_after_reset");
        ticks(4);
        rd(32'h4, 32'h2, "level_trip_redetected");
        rd(32'h0, 32'h2, "event_trip_redetected");
        rd(32'h8, 32'h0000_0100, "count_trip_redetected");
        chk("hreadyout_end", {31'd0, bus.HREADYOUT}, 32'd1);
        nTrip = 1'b1;
        ticks(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
